multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/ctrl_pkg.sv | 50 +++++
 rtl/ctrl_decode.sv | 34 +++
 rtl/multicycle_control_unit.sv | 158 +++++++++++++++
 tb/tb_multicycle_control_unit.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// datapath select codes and the instruction classes produced by ctrl_decode.
package ctrl_pkg;

   localparam logic [3:0] OP_LW   = 4'h0;
   localparam logic [3:0] OP_SW   = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_ADDI = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_NOT  = 4'h5;
   localparam logic [3:0] OP_SHL  = 4'h6;
   localparam logic [3:0] OP_SHR  = 4'h7;
   localparam logic [3:0] OP_AND  = 4'h8;
   localparam logic [3:0] OP_OR   = 4'h9;
   localparam logic [3:0] OP_BEQ  = 4'hA;
   localparam logic [3:0] OP_BNE  = 4'hB;
   localparam logic [3:0] OP_JUMP = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5,
      S_TRAP   = 3'd6
   } state_e;

   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_MEM  = 2'b01;
   localparam logic [1:0] ALUOP_BR   = 2'b10;

   localparam logic [1:0] ALUSRC_REG = 2'b00;
   localparam logic [1:0] ALUSRC_MEM = 2'b01;
   localparam logic [1:0] ALUSRC_IMM = 2'b10;

   localparam logic [1:0] PCSRC_INC  = 2'b00;
   localparam logic [1:0] PCSRC_BR   = 2'b01;
   localparam logic [1:0] PCSRC_JMP  = 2'b10;

   localparam logic [2:0] CLS_MEM     = 3'd0;
   localparam logic [2:0] CLS_ALU_REG = 3'd1;
   localparam logic [2:0] CLS_ALU_IMM = 3'd2;
   localparam logic [2:0] CLS_BRANCH  = 3'd3;
   localparam logic [2:0] CLS_JUMP    = 3'd4;
   localparam logic [2:0] CLS_HALT    = 3'd5;
   localparam logic [2:0] CLS_ILLEGAL = 3'd6;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; any opcode bit above bit 3 makes the
// instruction illegal regardless of the low nibble.
module ctrl_decode
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4
) (
   input  logic [OPCODE_W-1:0] op,
   output logic [2:0]          cls
);

   logic [3:0] op4;
   logic       hi_set;

   assign op4    = op[3:0];
   assign hi_set = |(op >> 4);

   always_comb begin
      cls = CLS_ILLEGAL;
      if (!hi_set) begin
         case (op4)
            OP_LW, OP_SW:                cls = CLS_MEM;
            OP_ADDI:                     cls = CLS_ALU_IMM;
            OP_ADD, OP_SUB, OP_NOT, OP_SHL,
            OP_SHR, OP_AND, OP_OR:       cls = CLS_ALU_REG;
            OP_BEQ, OP_BNE:              cls = CLS_BRANCH;
            OP_JUMP:                     cls = CLS_JUMP;
            OP_HALT:                     cls = CLS_HALT;
            default:                     cls = CLS_ILLEGAL;
         endcase
      end
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle FSM control unit (FETCH/DECODE/EXEC/MEM/WB plus absorbing HALT/TRAP).
// Optional performance counters are enabled with macro CTRL_PERF_CNT_EN.
module multicycle_control_unit
   import ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int CNT_W    = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pc_write,
   output logic                ir_write,
   output logic [1:0]          pc_src,
   output logic [1:0]          ALUOp,
   output logic [1:0]          ALUSrc,
   output logic                regDst,
   output logic                MemRead,
   output logic                MemtoReg,
   output logic                MemWrite,
   output logic                RegWrite,
   output logic                halted,
   output logic                illegal,
   output logic [2:0]          state
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]    cycle_cnt,
   output logic [CNT_W-1:0]    instr_cnt
`endif
);

   state_e              st, nxt;
   logic [OPCODE_W-1:0] op_q, op_sel;
   logic [2:0]          cls;
   logic                halted_q, illegal_q;
   logic [3:0]          op4;

   // DECODE must classify the live opcode since op_q only loads at its end.
   assign op_sel = (st == S_DECODE) ? Opcode : op_q;
   assign op4    = op_q[3:0];

   ctrl_decode #(.OPCODE_W(OPCODE_W)) u_dec (
      .op  (op_sel),
      .cls (cls)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= S_FETCH;
         op_q      <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         st <= nxt;
         if (st == S_DECODE) op_q <= Opcode;
         if (nxt == S_HALT)  halted_q  <= 1'b1;
         if (nxt == S_TRAP)  illegal_q <= 1'b1;
      end
   end

   always_comb begin
      nxt      = st;
      pc_write = 1'b0;
      ir_write = 1'b0;
      pc_src   = PCSRC_INC;
      ALUOp    = ALUOP_ADD;
      ALUSrc   = ALUSRC_REG;
      regDst   = 1'b0;
      MemRead  = 1'b0;
      MemtoReg = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      case (st)
         S_FETCH: begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            nxt      = S_DECODE;
         end
         S_DECODE: begin
            if (cls == CLS_HALT)         nxt = S_HALT;
            else if (cls == CLS_ILLEGAL) nxt = S_TRAP;
            else                         nxt = S_EXEC;
         end
         S_EXEC: begin
            nxt = S_FETCH;
            case (cls)
               CLS_MEM: begin
                  ALUOp  = ALUOP_MEM;
                  ALUSrc = ALUSRC_MEM;
                  nxt    = S_MEM;
               end
               CLS_ALU_IMM: begin
                  ALUSrc = ALUSRC_IMM;
                  nxt    = S_WB;
               end
               CLS_ALU_REG: nxt = S_WB;
               CLS_BRANCH: begin
                  ALUOp    = ALUOP_BR;
                  pc_src   = PCSRC_BR;
                  pc_write = (op4 == OP_BNE) ? !zero : zero;
               end
               CLS_JUMP: begin
                  pc_src   = PCSRC_JMP;
                  pc_write = 1'b1;
               end
               default: nxt = S_FETCH;
            endcase
         end
         S_MEM: begin
            // The access strobe stays up until the memory acknowledges.
            if (op4 == OP_LW) MemRead  = 1'b1;
            else              MemWrite = 1'b1;
            if (mem_ready) nxt = (op4 == OP_LW) ? S_WB : S_FETCH;
         end
         S_WB: begin
            RegWrite = 1'b1;
            MemtoReg = (cls == CLS_MEM);
            regDst   = (cls == CLS_ALU_REG);
            nxt      = S_FETCH;
         end
         S_HALT, S_TRAP: nxt = st;
         default: nxt = S_FETCH;
      endcase
      // Reset has to silence the datapath even in the cycle it is sampled.
      if (rst) begin
         pc_write = 1'b0;
         ir_write = 1'b0;
         pc_src   = PCSRC_INC;
         ALUOp    = ALUOP_ADD;
         ALUSrc   = ALUSRC_REG;
         regDst   = 1'b0;
         MemRead  = 1'b0;
         MemtoReg = 1'b0;
         MemWrite = 1'b0;
         RegWrite = 1'b0;
      end
   end

   assign halted  = halted_q;
   assign illegal = illegal_q;
   assign state   = st;

`ifdef CTRL_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt <= '0;
         instr_cnt <= '0;
      end else begin
         if (st != S_HALT && st != S_TRAP) cycle_cnt <= cycle_cnt + 1'b1;
         if (nxt == S_FETCH && (st == S_EXEC || st == S_MEM || st == S_WB))
            instr_cnt <= instr_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: randomized instruction streams compared per cycle
// against a trace model built from the instruction-level rules.
module tb_multicycle_control_unit;

   localparam int OW = 5;
   localparam int CW = 4;

   localparam logic [17:0] PCW      = 18'h04000;
   localparam logic [17:0] IRW      = 18'h02000;
   localparam logic [17:0] PCS_JMP  = 18'h01000;
   localparam logic [17:0] PCS_BR   = 18'h00800;
   localparam logic [17:0] AOP_BR   = 18'h00400;
   localparam logic [17:0] AOP_MEM  = 18'h00200;
   localparam logic [17:0] ASRC_IMM = 18'h00100;
   localparam logic [17:0] ASRC_MEM = 18'h00080;
   localparam logic [17:0] RD       = 18'h00040;
   localparam logic [17:0] MR       = 18'h00020;
   localparam logic [17:0] M2R      = 18'h00010;
   localparam logic [17:0] MW       = 18'h00008;
   localparam logic [17:0] RW       = 18'h00004;
   localparam logic [17:0] HLT      = 18'h00002;
   localparam logic [17:0] ILL      = 18'h00001;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [OW-1:0] Opcode = '0;
   logic          zero = 1'b0;
   logic          mem_ready = 1'b0;
   logic          pc_write, ir_write, regDst, MemRead, MemtoReg, MemWrite, RegWrite;
   logic          halted, illegal;
   logic [1:0]    pc_src, ALUOp, ALUSrc;
   logic [2:0]    state;
   logic [17:0]   obs;
`ifdef CTRL_PERF_CNT_EN
   logic [CW-1:0] cycle_cnt, instr_cnt;
`endif

   int tests = 0;
   int fails = 0;
   int tb_cyc = 0;
   int tb_ins = 0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.OPCODE_W(OW), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .Opcode    (Opcode),
      .zero      (zero),
      .mem_ready (mem_ready),
      .pc_write  (pc_write),
      .ir_write  (ir_write),
      .pc_src    (pc_src),
      .ALUOp     (ALUOp),
      .ALUSrc    (ALUSrc),
      .regDst    (regDst),
      .MemRead   (MemRead),
      .MemtoReg  (MemtoReg),
      .MemWrite  (MemWrite),
      .RegWrite  (RegWrite),
      .halted    (halted),
      .illegal   (illegal),
      .state     (state)
`ifdef CTRL_PERF_CNT_EN
      ,
      .cycle_cnt (cycle_cnt),
      .instr_cnt (instr_cnt)
`endif
   );

   assign obs = {state, pc_write, ir_write, pc_src, ALUOp, ALUSrc,
                 regDst, MemRead, MemtoReg, MemWrite, RegWrite, halted, illegal};

   function automatic logic [17:0] st(input int s);
      logic [17:0] t;
      t = 18'(s);
      return t << 15;
   endfunction

   // Entered and left just after a falling edge; leaves rst low with the DUT in FETCH.
   task automatic do_reset(input int n);
      rst = 1'b1;
      Opcode = OW'($urandom);
      mem_ready = 1'($urandom);
      #1;
      tests++;
      if (obs[14:2] !== 13'h0) begin
         fails++;
         $display("FAIL rst_strobes: got %h expected 0", obs[14:2]);
      end
      @(negedge clk);
      repeat (n) begin
         Opcode = OW'($urandom);
         mem_ready = 1'($urandom);
         #1;
         tests++;
         if (obs !== 18'h0) begin
            fails++;
            $display("FAIL rst_state: got %h expected %h", obs, 18'h0);
         end
`ifdef CTRL_PERF_CNT_EN
         tests++;
         if (cycle_cnt !== '0 || instr_cnt !== '0) begin
            fails++;
            $display("FAIL rst_cnt: got %0d/%0d expected 0/0", cycle_cnt, instr_cnt);
         end
`endif
         @(negedge clk);
      end
      rst = 1'b0;
      tb_cyc = 0;
      tb_ins = 0;
   endtask

   // Builds the expected per-cycle trace of one instruction and plays it.
   // For MEM ops wait_n is the number of not-ready cycles; for HALT/TRAP it
   // is the number of absorbing cycles observed. max_rec < 0 plays all.
   task automatic run_instr(input logic [OW-1:0] op, input logic z, input int wait_n,
                            input int max_rec, input string tag);
      logic [17:0] expq[$];
      bit          mrq[$];
      bit          endq[$];
      int          n;
      expq.push_back(st(0) | PCW | IRW); mrq.push_back(1'($urandom)); endq.push_back(0);
      expq.push_back(st(1));             mrq.push_back(1'($urandom)); endq.push_back(0);
      if (op > 15 || op == 13 || op == 14) begin
         repeat (wait_n) begin
            expq.push_back(st(6) | ILL); mrq.push_back(1'($urandom)); endq.push_back(0);
         end
      end else if (op == 15) begin
         repeat (wait_n) begin
            expq.push_back(st(5) | HLT); mrq.push_back(1'($urandom)); endq.push_back(0);
         end
      end else begin
         case (op)
            0, 1: begin
               expq.push_back(st(2) | AOP_MEM | ASRC_MEM); mrq.push_back(1'($urandom)); endq.push_back(0);
               for (int i = 0; i <= wait_n; i++) begin
                  expq.push_back(st(3) | ((op == 0) ? MR : MW));
                  mrq.push_back(i == wait_n);
                  endq.push_back(op == 1 && i == wait_n);
               end
               if (op == 0) begin
                  expq.push_back(st(4) | RW | M2R); mrq.push_back(1'($urandom)); endq.push_back(1);
               end
            end
            3: begin
               expq.push_back(st(2) | ASRC_IMM); mrq.push_back(1'($urandom)); endq.push_back(0);
               expq.push_back(st(4) | RW);       mrq.push_back(1'($urandom)); endq.push_back(1);
            end
            10, 11: begin
               expq.push_back(st(2) | AOP_BR | PCS_BR | (((op == 10) ? z : !z) ? PCW : 18'h0));
               mrq.push_back(1'($urandom)); endq.push_back(1);
            end
            12: begin
               expq.push_back(st(2) | PCW | PCS_JMP); mrq.push_back(1'($urandom)); endq.push_back(1);
            end
            default: begin
               expq.push_back(st(2));           mrq.push_back(1'($urandom)); endq.push_back(0);
               expq.push_back(st(4) | RW | RD); mrq.push_back(1'($urandom)); endq.push_back(1);
            end
         endcase
      end
      n = (max_rec >= 0 && max_rec < expq.size()) ? max_rec : expq.size();
      for (int i = 0; i < n; i++) begin
         Opcode = (i == 1) ? op : OW'($urandom);
         zero = (i == 2) ? z : 1'($urandom);
         mem_ready = mrq[i];
         #1;
         tests++;
         if (obs !== expq[i]) begin
            fails++;
            $display("FAIL %s op=%h cyc%0d: got %h expected %h", tag, op, i, obs, expq[i]);
         end
`ifdef CTRL_PERF_CNT_EN
         tests++;
         if (cycle_cnt !== CW'(tb_cyc) || instr_cnt !== CW'(tb_ins)) begin
            fails++;
            $display("FAIL %s_cnt cyc%0d: got %0d/%0d expected %0d/%0d", tag, i,
                     cycle_cnt, instr_cnt, CW'(tb_cyc), CW'(tb_ins));
         end
`endif
         if (expq[i][17:15] != 3'd5 && expq[i][17:15] != 3'd6) tb_cyc++;
         if (endq[i]) tb_ins++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      do_reset(3);
   endtask

   task automatic test_add();
      do_reset(2);
      run_instr(5'h02, 1'b0, 0, -1, "add");
`ifdef CTRL_PERF_CNT_EN
      tests++;
      if (instr_cnt !== 4'd1) begin
         fails++;
         $display("FAIL add_instr_cnt: got %0d expected 1", instr_cnt);
      end
`endif
   endtask

   task automatic test_lw();
      run_instr(5'h00, 1'b0, 3, -1, "lw");
      run_instr(5'h00, 1'b1, 0, -1, "lw_fast");
      run_instr(5'h03, 1'b0, 0, -1, "addi");
   endtask

   task automatic test_branch();
      logic [OW-1:0] ops[5];
      logic          zs[5];
      ops = '{5'h0A, 5'h0B, 5'h0A, 5'h0B, 5'h0C};
      zs  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 5; i++) run_instr(ops[i], zs[i], 0, -1, "branch");
   endtask

   task automatic test_back_to_back();
      repeat (40) begin
         run_instr(OW'($urandom_range(0, 12)), 1'($urandom), int'($urandom_range(0, 3)),
                   -1, "random");
      end
   endtask

   task automatic test_mem_reset();
      run_instr(5'h01, 1'b0, 3, 4, "sw_part");
      rst = 1'b1;
      mem_ready = 1'b0;
      #1;
      tests++;
      if (obs !== st(3)) begin
         fails++;
         $display("FAIL sw_rst_cycle: got %h expected %h", obs, st(3));
      end
      @(negedge clk);
      rst = 1'b0;
      tb_cyc = 0;
      tb_ins = 0;
      #1;
      tests++;
      if (obs !== (st(0) | PCW | IRW)) begin
         fails++;
         $display("FAIL sw_rst_fetch: got %h expected %h", obs, st(0) | PCW | IRW);
      end
      run_instr(5'h01, 1'b0, 2, -1, "sw");
   endtask

   task automatic test_trap();
      logic [OW-1:0] ops[3];
      ops = '{5'h0E, 5'h0D, 5'h12};
      for (int i = 0; i < 3; i++) begin
         run_instr(ops[i], 1'b0, 10, -1, "trap");
         do_reset(1);
         #1;
         tests++;
         if (obs !== (st(0) | PCW | IRW)) begin
            fails++;
            $display("FAIL trap_clear: got %h expected %h", obs, st(0) | PCW | IRW);
         end
      end
   endtask

   task automatic test_halt();
      do_reset(1);
      repeat (5) run_instr(5'h02, 1'b0, 0, -1, "wrap");
      run_instr(5'h0F, 1'b0, 10, -1, "halt");
      do_reset(1);
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_branch();
      test_back_to_back();
      test_mem_reset();
      test_trap();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
